apb_ib_cmd_master: RTL

- APB initiator that drives the input-buffer-port APB register file (token/program cfg, packet token id, packet word data, OPU index/payload/release/status) from a host-side command stream.
- Sits between a command source (sequencer or debug UART bridge) and the input buffer port's APB responder.
- Buffers commands in a small FIFO, runs the APB setup/access phases, waits on pready, and returns one response per command over a valid/ready channel.

---
 rtl/apb_ib_cmd_master_pkg.sv | 29 ++
 rtl/apb_mst_cmd_fifo.sv | 56 +++++
 rtl/apb_ib_cmd_master.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/apb_ib_cmd_master_pkg.sv
// Shared definitions for the input-buffer-port APB command master:
// responder register map, master FSM encoding and command record sizing.
package apb_ib_cmd_master_pkg;

   // Input buffer port APB register map (byte addresses, shared with the responder)
   localparam logic [5:0] REG_TOKEN_CFG    = 6'h00;
   localparam logic [5:0] REG_PROG_CFG     = 6'h04;
   localparam logic [5:0] REG_PKT_TOKEN_ID = 6'h10;
   localparam logic [5:0] REG_PKT_CTRL     = 6'h14;
   localparam logic [5:0] REG_PKT_WDATA    = 6'h20;
   localparam logic [5:0] REG_PKT_STATUS   = 6'h24;
   localparam logic [5:0] REG_OPU_INDEX    = 6'h30;
   localparam logic [5:0] REG_OPU_PAYLOAD  = 6'h34;
   localparam logic [5:0] REG_OPU_RELEASE  = 6'h38;
   localparam logic [5:0] REG_OPU_STATUS   = 6'h3C;

   // Master FSM encoding
   typedef logic [1:0] fsm_state_t;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   // Command record layout is {addr, write, wdata}
   function automatic int cmd_rec_w(input int aw, input int dw);
      return aw + 1 + dw;
   endfunction

endpackage

// File: rtl/apb_mst_cmd_fifo.sv
// Small synchronous command FIFO. The head entry is presented combinationally
// so the master can load it straight into its APB output registers on pop.
// A push while full is accepted only when a pop happens in the same cycle.
module apb_mst_cmd_fifo #(
   parameter int DW    = 39,
   parameter int DEPTH = 4
)(
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  logic [DW-1:0]            wdata_i,
   input  logic                     pop_i,
   output logic [DW-1:0]            rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [PW:0]   count_reg;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_reg == (PW+1)'(DEPTH));
   assign empty_o = (count_reg == '0);
   assign count_o = count_reg;
   assign rdata_o = mem[rd_ptr_reg];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Storage write; no reset needed on the data array
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr_reg] <= wdata_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/apb_ib_cmd_master.sv
// APB initiator for the input buffer port register file. Commands are queued
// in a FIFO, executed one APB transfer each (setup, access, wait on pready),
// and answered in order over a valid/ready response channel.
// Optional build macro APB_TIMEOUT_EN: bounds the access phase to
// TIMEOUT_CYCLES cycles and flags aborted transfers on rsp_err_o.
module apb_ib_cmd_master
   import apb_ib_cmd_master_pkg::*;
#(
   parameter int BUS_AW         = 6,
   parameter int BUS_DW         = 32,
   parameter int CMD_FIFO_DEPTH = 4,
   parameter int TIMEOUT_CYCLES = 64
)(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [BUS_AW-1:0] cmd_addr_i,
   input  logic              cmd_write_i,
   input  logic [BUS_DW-1:0] cmd_wdata_i,
   input  logic              cmd_vld_i,
   output logic              cmd_rdy_o,
   output logic [BUS_DW-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              rsp_vld_o,
   input  logic              rsp_rdy_i,
   output logic [BUS_AW-1:0] apb_paddr_m,
   output logic              apb_pwrite_m,
   output logic              apb_psel_m,
   output logic              apb_penable_m,
   output logic [BUS_DW-1:0] apb_pwdata_m,
   input  logic [BUS_DW-1:0] apb_prdata_m,
   input  logic              apb_pready_m,
   output logic              busy_o
);
   localparam int CMD_W = cmd_rec_w(BUS_AW, BUS_DW);
   localparam int CNT_W = $clog2(CMD_FIFO_DEPTH) + 1;

   logic [CMD_W-1:0]  fifo_wdata;
   logic [CMD_W-1:0]  fifo_rdata;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  unused_fifo_count;

   fsm_state_t        state_reg;
   logic [BUS_AW-1:0] paddr_reg;
   logic              pwrite_reg;
   logic [BUS_DW-1:0] pwdata_reg;
   logic              psel_reg;
   logic              penable_reg;
   logic [BUS_DW-1:0] rsp_rdata_reg;
   logic              rsp_vld_reg;

   assign fifo_wdata = {cmd_addr_i, cmd_write_i, cmd_wdata_i};
   assign fifo_push  = cmd_vld_i && !fifo_full;
   // A new transfer starts from IDLE, or straight from RESP once the pending response is taken
   assign fifo_pop   = !fifo_empty &&
                       ((state_reg == ST_IDLE) || ((state_reg == ST_RESP) && rsp_rdy_i));

   apb_mst_cmd_fifo #(
      .DW    (CMD_W),
      .DEPTH (CMD_FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (unused_fifo_count)
   );

`ifdef APB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TMO_W-1:0] tmo_cnt_reg;
   logic             tmo_hit;
   logic             rsp_err_reg;

   assign tmo_hit   = (state_reg == ST_ACCESS) && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
   assign rsp_err_o = rsp_err_reg;

   // Access-phase wait counter: zero outside ACCESS, counts cycles without pready
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                    tmo_cnt_reg <= '0;
      else if (state_reg != ST_ACCESS) tmo_cnt_reg <= '0;
      else if (!apb_pready_m)          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
   end
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
   assign rsp_err_o      = 1'b0;
`endif

   // Address/direction/data registers load from the FIFO head on every pop and hold otherwise
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         paddr_reg  <= '0;
         pwrite_reg <= 1'b0;
         pwdata_reg <= '0;
      end else if (fifo_pop) begin
         paddr_reg  <= fifo_rdata[CMD_W-1 -: BUS_AW];
         pwrite_reg <= fifo_rdata[BUS_DW];
         pwdata_reg <= fifo_rdata[BUS_DW-1:0];
      end
   end

   // Transfer sequencing: IDLE -> SETUP -> ACCESS -> RESP, with RESP chaining into SETUP
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg     <= ST_IDLE;
         psel_reg      <= 1'b0;
         penable_reg   <= 1'b0;
         rsp_vld_reg   <= 1'b0;
         rsp_rdata_reg <= '0;
`ifdef APB_TIMEOUT_EN
         rsp_err_reg   <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (fifo_pop) begin
                  psel_reg    <= 1'b1;
                  penable_reg <= 1'b0;
                  state_reg   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_reg <= 1'b1;
               state_reg   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (apb_pready_m) begin
                  rsp_rdata_reg <= pwrite_reg ? '0 : apb_prdata_m;
`ifdef APB_TIMEOUT_EN
                  rsp_err_reg   <= 1'b0;
`endif
                  psel_reg      <= 1'b0;
                  penable_reg   <= 1'b0;
                  rsp_vld_reg   <= 1'b1;
                  state_reg     <= ST_RESP;
               end
`ifdef APB_TIMEOUT_EN
               else if (tmo_hit) begin
                  rsp_rdata_reg <= '0;
                  rsp_err_reg   <= 1'b1;
                  psel_reg      <= 1'b0;
                  penable_reg   <= 1'b0;
                  rsp_vld_reg   <= 1'b1;
                  state_reg     <= ST_RESP;
               end
`endif
            end
            ST_RESP: begin
               if (rsp_rdy_i) begin
                  rsp_vld_reg <= 1'b0;
                  if (fifo_pop) begin
                     psel_reg  <= 1'b1;
                     state_reg <= ST_SETUP;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign cmd_rdy_o     = !fifo_full;
   assign rsp_rdata_o   = rsp_rdata_reg;
   assign rsp_vld_o     = rsp_vld_reg;
   assign apb_paddr_m   = paddr_reg;
   assign apb_pwrite_m  = pwrite_reg;
   assign apb_psel_m    = psel_reg;
   assign apb_penable_m = penable_reg;
   assign apb_pwdata_m  = pwdata_reg;
   assign busy_o        = (state_reg != ST_IDLE) || !fifo_empty;

endmodule
